// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer; strobes when the lane-3 byte arrives.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int LW = $clog2(WORD_BYTES);
  localparam logic [LW-1:0] LAST = LW'(WORD_BYTES - 1);

  logic [LW-1:0] lane_q;
  logic [23:0]   acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else if (in_valid) begin
      lane_q <= lane_q + 1'b1;
      case (lane_q)
        2'd0:    acc_q[7:0]   <= in_data;
        2'd1:    acc_q[15:8]  <= in_data;
        2'd2:    acc_q[23:16] <= in_data;
        default: ;
      endcase
    end
  end

  // The top byte bypasses storage so the word is ready on the lane-3 cycle.
  assign word       = {in_data, acc_q};
  assign word_valid = in_valid && (lane_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: fills instruction memory, then releases the core.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              core_enable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e      state_q, state_d;
  logic [1:0]  err_d;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [7:0]  csum_q;
  logic [31:0] idle_q;
  logic        accept, start_ok, timed, tmo;
  logic        last_word, word_valid;
  logic [31:0] word;
  logic [16:0] len_full;

  assign rx_ready  = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign timed     = state_q inside {S_LEN1, S_DATA, S_CSUM};
  assign tmo       = (TIMEOUT != 0) && timed && !accept
                     && (idle_q == 32'(TIMEOUT - 1));
  assign len_full  = {1'b0, rx_data, len_lo_q};
  assign last_word = {1'b0, len_q} == (17'(word_count) + 17'd1);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .in_valid  (accept && (state_q == S_DATA)),
    .in_data   (rx_data),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_d = S_LEN0;
      S_LEN0:
        if (accept) state_d = S_LEN1;
      S_LEN1:
        if (accept) begin
          if (len_full > CAP) begin
            state_d = S_ERROR;
            err_d   = ERR_LEN;
          end else if (len_full == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      S_DATA:
        if (word_valid && last_word) state_d = S_CSUM;
      S_CSUM:
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CSUM;
          end
        end
      default: state_d = S_IDLE;
    endcase
    // tmo excludes accept cycles, so it never races a byte-driven move.
    if (tmo) begin
      state_d = S_ERROR;
      err_d   = ERR_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst    <= 1'b1;
      core_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      word_count  <= '0;
    end else begin
      state_q     <= state_d;
      imem_we     <= word_valid;
      busy        <= state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
      done        <= state_d == S_DONE;
      error       <= state_d == S_ERROR;
      core_rst    <= state_d != S_DONE;
      core_enable <= state_d == S_DONE;

      if (accept || !timed) idle_q <= '0;
      else                  idle_q <= idle_q + 32'd1;

      if (accept && state_q == S_LEN0) len_lo_q <= rx_data;
      if (accept && state_q == S_LEN1) len_q <= {rx_data, len_lo_q};
      if (accept && state_q == S_DATA) csum_q <= csum_q ^ rx_data;

      if (word_valid) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= word;
        word_count <= word_count + 1'b1;
      end

      if (state_d == S_ERROR && state_q != S_ERROR) err_code <= err_d;

      if (start_ok) begin
        csum_q     <= '0;
        idle_q     <= '0;
        imem_addr  <= '0;
        word_count <= '0;
        err_code   <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frames checked against a queue-based model of expected writes.
module tb_imem_loader;

  localparam int AW  = 8;
  localparam int TMO = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst, core_enable, busy, done, error;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_enable(core_enable), .busy(busy),
    .done(done), .error(error), .err_code(err_code),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int         tests = 0;
  int         fails = 0;
  wr_t        exp_q[$];
  logic [7:0] pl[$];
  bit         prev_we = 1'b0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (imem_we) begin
        check("we_single_cycle", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected none",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_wdata, e.data);
        end
      end
      prev_we = imem_we;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(rx_ready), 32'd1);
    check("start_flags", {done, error, err_code}, 32'd0);
    check("start_wc", 32'(word_count), 32'd0);
    check("start_core", {core_rst, core_enable}, 32'b10);
  endtask

  task automatic check_end(input bit ok, input int code, input int wc);
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_code", 32'(err_code), 32'(code));
    check("end_wc", 32'(word_count), 32'(wc));
    check("end_core_rst", 32'(core_rst), 32'(!ok));
    check("end_core_en", 32'(core_enable), 32'(ok));
    check("end_busy", {busy, rx_ready}, 32'd0);
    check("end_writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_frame(input int len, input logic [7:0] c,
                            input int maxgap);
    send_byte(8'(len), $urandom_range(0, 5));
    send_byte(8'(len >> 8), $urandom_range(0, maxgap));
    foreach (pl[i]) send_byte(pl[i], $urandom_range(0, maxgap));
    send_byte(c, $urandom_range(0, maxgap));
  endtask

  task automatic run_frame(input int len, input bit bad, input int maxgap);
    logic [7:0] c;
    logic [7:0] b;
    pl.delete();
    c = 8'h00;
    if (len > CAP) begin
      do_start();
      send_byte(8'(len), $urandom_range(0, 5));
      send_byte(8'(len >> 8), $urandom_range(0, maxgap));
      check_end(1'b0, 1, 0);
      return;
    end
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      pl.push_back(b);
      c ^= b;
    end
    if (bad) c ^= 8'($urandom_range(1, 255));
    for (int w = 0; w < len; w++)
      exp_q.push_back('{w, {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]}});
    do_start();
    send_frame(len, c, maxgap);
    check_end(!bad, bad ? 2 : 0, len);
  endtask

  task automatic load_demo();
    pl.delete();
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back('{0, 32'h0000_0013});
    exp_q.push_back('{1, 32'h0010_0093});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready_we", {rx_ready, imem_we}, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core", {core_rst, core_enable}, 32'b10);
    check("rst_status", {busy, done, error, err_code}, 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b0;
    rx_valid = 1'b1;
    @(negedge clk);
    check("idle_no_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

    // Known program, plus a start pulse that must be ignored mid-frame.
    load_demo();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", {busy, rx_ready}, 32'b11);
    foreach (pl[i]) send_byte(pl[i], 0);
    send_byte(8'h90, 0);
    check_end(1'b1, 0, 2);

    load_demo();
    do_start();
    send_frame(2, 8'h91, 2);
    check_end(1'b0, 2, 2);

    run_frame(32'h0101, 1'b0, 2);
    run_frame(0, 1'b0, 2);

    // Stall after two payload bytes.
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd10);
    check_end(1'b0, 3, 0);

    // Reset inside the second word, then a clean reload.
    load_demo();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_we", {rx_ready, imem_we}, 32'd0);
    check("mid_rst_addr_data", {24'(imem_addr), imem_wdata[7:0]}, 32'd0);
    check("mid_rst_core", {core_rst, core_enable}, 32'b10);
    check("mid_rst_status", {busy, done, error, err_code}, 32'd0);
    check("mid_rst_wc", 32'(word_count), 32'd0);
    check("mid_rst_writes_left", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    load_demo();
    do_start();
    send_frame(2, 8'h90, 1);
    check_end(1'b1, 0, 2);

    run_frame(CAP, 1'b0, 0);

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 7) == 0)
        run_frame($urandom_range(CAP + 1, 65535), 1'b0, 3);
      else
        run_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0, 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core and its instruction memory. It accepts a framed byte stream (2-byte length, payload, 1-byte XOR checksum) over a valid/ready interface. It packs the payload little-endian into 32-bit words and writes them sequentially into instruction memory from word address 0. It holds the core in reset with `enable` low until a frame completes with a correct checksum, then releases it.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT`, 1000: maximum idle cycles allowed between accepted bytes inside a frame; 0 disables the timeout.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte; transfer occurs when `rx_valid && rx_ready`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: write data.
- `core_rst` out 1: reset to the core (drives the core's `rst`).
- `core_enable` out 1: drives the core's `enable`.
- `busy` out 1: a frame is in progress.
- `done` out 1: the last frame loaded successfully.
- `error` out 1: the last frame failed.
- `err_code` out 2: 0 none, 1 length overflow, 2 checksum mismatch, 3 timeout.
- `word_count` out ADDR_W+1: words written in the current or last frame.

## Operation
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `core_enable`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `word_count`=0. State is IDLE.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → LEN0. On this transition:
  - clear `done`, `error`, `err_code`, `word_count`, the byte lane index, the checksum accumulator and the address;
  - set `core_rst`=1 and `core_enable`=0;
  - set `busy`=1.
- `rx_ready`=1 exactly in LEN0, LEN1, DATA and CSUM.
- LEN0: the accepted byte is the length LSB (in words). Go to LEN1.
- LEN1: the accepted byte is the length MSB.
  - If length > 2^ADDR_W → ERROR, code 1.
  - If length = 0 → CSUM.
  - Otherwise → DATA.
- DATA handling:
  - Each accepted byte is XORed into the checksum and placed in lane 0..3; lane 0 is bits [7:0].
  - Acceptance of lane 3 completes a word.
  - On the next cycle: `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word, and `word_count` increments.
  - After the final word's lane-3 byte → CSUM.
- CSUM: the accepted byte is compared with the accumulator (0x00 for an empty frame).
  - Equal → DONE.
  - Unequal → ERROR, code 2.
- DONE: `core_rst`=0, `core_enable`=1, `done`=1, `busy`=0.
- ERROR: `core_rst`=1, `core_enable`=0, `error`=1, `busy`=0.
- Timeout covers LEN1, DATA and CSUM. An idle counter resets on every accepted byte. When it reaches TIMEOUT, go to ERROR with code 3. The timeout is inactive in LEN0, so the host may delay the first byte indefinitely.
- `start` while `busy` is ignored.
- Bytes presented outside LEN0..CSUM are not accepted (`rx_ready`=0).
- Words already written before an error remain in memory; the core stays in reset.

## Timing
- Byte acceptance is single-cycle; back-to-back bytes are sustained at 1 byte/cycle.
- Write latency: `imem_we` is asserted 1 cycle after the lane-3 byte is accepted. All write outputs are registered. `imem_we` is never high for two consecutive cycles.
- The final word's write and entry to CSUM occur in the same cycle.
- State outputs change 1 cycle after the qualifying byte or `start`. `core_rst` falls and `core_enable` rises in the same cycle.
- `rst` mid-frame aborts immediately to reset values. No partial word is written.
- Address wrap: a length of exactly 2^ADDR_W writes addresses 0..2^ADDR_W−1 with no wrap. Larger lengths are rejected before any write.

## Structure
- Shared `loader_pkg` holds:
  - the state enum;
  - the `err_code` constants (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO);
  - the frame constants: header length 2 and bytes per word 4.
- One sub-module, `word_packer`: byte lanes, lane counter and word-complete strobe. It is cleared on `start` and on `rst`.
- All other logic stays in `imem_loader`: FSM, checksum, timeout counter, address/count registers and core control.

## Test plan
- Frame len=2 with bytes 13 00 00 00, 93 00 10 00 and csum 0x90:
  - writes 0x00000013 @0 and 0x00100093 @1;
  - then DONE, `core_rst`=0, `core_enable`=1, `word_count`=2.
- Same payload with csum 0x91 → ERROR, `err_code`=2, `core_rst`=1, both words still written.
- len=0x0101 with ADDR_W=8 → ERROR code 1 after the MSB byte, no `imem_we`.
- len=0 then csum 0x00 → DONE with `word_count`=0.
- TIMEOUT=10, stall after 2 payload bytes → ERROR code 3 exactly 10 cycles after the last accepted byte.
- Assert `rst` in the middle of word 1 → all outputs at reset values next cycle. A new `start` plus the full frame then loads correctly.
